// File: rtl/his_builder_pp.sv
// Ping-pong per-pixel histogram builder: one bank accumulates TDC hits while
// the other is drained with read-and-clear; banks swap on frame completion.
module his_builder_pp #(
  parameter int NB      = 6,
  parameter int CW      = 8,
  parameter int NPIX    = 4,
  parameter int PW      = 2,
  parameter int ACQ_NUM = 1000,
  parameter int AW      = 20
) (
  input  logic          clk,
  input  logic          res,
  input  logic          wr_en,
  input  logic [PW-1:0] pix,
  input  logic [NB-1:0] addr,
  input  logic          acq_end,
  input  logic          rd_en,
  input  logic [PW-1:0] rd_pix,
  input  logic [NB-1:0] rd_addr,
  input  logic          rd_done,
  output logic [CW-1:0] rd_data,
  output logic          rd_valid,
  output logic          his_num,
  output logic          frame_done,
  output logic          ovf,
  output logic [AW-1:0] acq_cnt
);

  localparam int NBIN = 2 ** NB;
  localparam logic [CW-1:0] CMAX   = {CW{1'b1}};
  localparam logic [PW:0]   NPIX_W = (PW + 1)'(NPIX);

  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] mem_r [2][NPIX][NBIN];
  logic          s1_vld_r, s1_bank_r;
  logic [PW-1:0] s1_pix_r;
  logic [NB-1:0] s1_addr_r;
  logic          released_r, swap_r;
  logic          swap_s, release_s, to_hold_s;
  logic          rd_bank_s, rd_in_range_s, wr_hit_s;
  logic [CW-1:0] wr_val_s, rd_val_s;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CMAX) return CMAX;
    else           return v + CW'(1);
  endfunction

  // Frame control: decides swap, release and the ACCUM/HOLD transition
  always_comb begin
    state_nxt_s = state_r;
    swap_s      = 1'b0;
    release_s   = 1'b0;
    to_hold_s   = 1'b0;
    case (state_r)
      ACCUM: begin
        release_s = rd_done;
        if (acq_end && (acq_cnt == AW'(ACQ_NUM - 1))) begin
          // a release arriving with the closing pulse counts as already given
          if (released_r || rd_done) begin
            swap_s = 1'b1;
          end else begin
            to_hold_s   = 1'b1;
            state_nxt_s = HOLD;
          end
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      HOLD: begin
        if (rd_done) begin
          swap_s      = 1'b1;
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = ACCUM;
    endcase
  end

  // State register and frame bookkeeping
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r    <= ACCUM;
      his_num    <= 1'b0;
      acq_cnt    <= '0;
      released_r <= 1'b1;
      ovf        <= 1'b0;
      swap_r     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      swap_r     <= swap_s;
      // delayed one edge so the last in-flight write has landed
      frame_done <= swap_r;
      if (swap_s) begin
        his_num    <= ~his_num;
        acq_cnt    <= '0;
        released_r <= 1'b0;
      end else if (to_hold_s) begin
        acq_cnt <= AW'(ACQ_NUM);
        ovf     <= 1'b1;
      end else begin
        if (release_s) released_r <= 1'b1;
        if ((state_r == ACCUM) && acq_end) acq_cnt <= acq_cnt + AW'(1);
      end
    end
  end

  // Stage 1 of the accumulate pipeline: capture hit and its bank
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s1_vld_r  <= 1'b0;
      s1_bank_r <= 1'b0;
      s1_pix_r  <= '0;
      s1_addr_r <= '0;
    end else begin
      s1_vld_r  <= wr_en && (state_r == ACCUM) && ({1'b0, pix} < NPIX_W);
      s1_bank_r <= his_num;
      s1_pix_r  <= pix;
      s1_addr_r <= addr;
    end
  end

  assign rd_bank_s     = ~his_num;
  assign rd_in_range_s = ({1'b0, rd_pix} < NPIX_W);
  assign wr_val_s      = sat_inc(mem_r[s1_bank_r][s1_pix_r][s1_addr_r]);
  assign wr_hit_s      = s1_vld_r && (s1_bank_r == rd_bank_s) &&
                         (s1_pix_r == rd_pix) && (s1_addr_r == rd_addr);

  // A read colliding with a landing write returns the incremented count
  always_comb begin
    rd_val_s = '0;
    if (!rd_in_range_s) rd_val_s = '0;
    else if (wr_hit_s)  rd_val_s = wr_val_s;
    else                rd_val_s = mem_r[rd_bank_s][rd_pix][rd_addr];
  end

  // Stage 2 write, read-and-clear (clear wins on collision) and read port
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int b = 0; b < 2; b++)
        for (int p = 0; p < NPIX; p++)
          for (int a = 0; a < NBIN; a++)
            mem_r[b][p][a] <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (s1_vld_r) mem_r[s1_bank_r][s1_pix_r][s1_addr_r] <= wr_val_s;
      if (rd_en && rd_in_range_s) mem_r[rd_bank_s][rd_pix][rd_addr] <= '0;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_val_s;
    end
  end

endmodule

// File: doc/his_builder_pp.md
# his_builder_pp

Parametrised ping-pong histogram builder for the dToF receive path. It accumulates TDC timestamps into per-pixel bin histograms over a fixed number of laser acquisitions. On frame completion it swaps banks so one bank accumulates while the other is read out, with read-and-clear readout. It sits between the TDC/pixel arbiter and the peak-detection/data-formatting stage.

## Interface
- NB, 6, timestamp (bin address) width; bins per pixel = 2^NB
- CW, 8, bin counter width; counters saturate at 2^CW-1
- NPIX, 4, pixels per histogram bank
- PW, 2, pixel index width, ≥ clog2(NPIX)
- ACQ_NUM, 1000, acquisitions (acq_end pulses) per frame
- AW, 20, acquisition counter width, ≥ clog2(ACQ_NUM+1)

- clk  in  1  single clock, all logic on rising edge
- res  in  1  reset, asynchronous, active-high
- wr_en  in  1  hit valid, one hit per cycle max
- pix  in  PW  pixel index of hit; values ≥ NPIX ignored
- addr  in  NB  timestamp bin of hit
- acq_end  in  1  one-cycle pulse marking end of one acquisition
- rd_en  in  1  read request on readout bank
- rd_pix  in  PW  read pixel index
- rd_addr  in  NB  read bin index
- rd_done  in  1  pulse: consumer has finished with readout bank (release)
- rd_data  out  CW  bin count, valid with rd_valid
- rd_valid  out  1  read data valid
- his_num  out  1  index of bank currently accumulating; readout bank = ~his_num
- frame_done  out  1  one-cycle pulse: readout bank holds a complete frame
- ovf  out  1  sticky: frame closed while readout bank unreleased
- acq_cnt  out  AW  acquisitions completed in current frame

## Operation
- Reset: all bins of both banks 0; his_num=0, frame_done=0, rd_data=0, rd_valid=0, ovf=0, acq_cnt=0; readout bank marked released; state ACCUM.
- ACCUM: hit increments bin [his_num][pix][addr] by 1, saturating at 2^CW-1. acq_end increments acq_cnt. acq_end that brings acq_cnt to ACQ_NUM closes the frame:
  - readout bank released → swap: his_num toggles, acq_cnt←0, readout bank marked unreleased, frame_done pulses; stay ACCUM.
  - readout bank unreleased → go HOLD, set ovf.
- HOLD: hits dropped, acq_end ignored, acq_cnt held at ACQ_NUM. On rd_done → swap (as above), return to ACCUM.
- Hit coincident with the closing acq_end counts in the closing frame.
- rd_done in ACCUM marks readout bank released; rd_done when already released ignored.
- Read: rd_en returns bin [~his_num][rd_pix][rd_addr] and clears that bin to 0 (read-and-clear). rd_pix ≥ NPIX returns 0, no clear. Reads allowed any time; a released, fully-read bank reads 0.
- ovf cleared only by reset.

## Timing
- Accumulate is a 2-stage read-modify-write (stage 1 registers hit + bank, stage 2 writes). Back-to-back hits to the same bin must both count (forwarding); N consecutive same-bin hits yield N (until saturation).
- In-flight stage-2 write carries its bank index; a swap never redirects it.
- his_num toggles on the edge sampling the closing acq_end (or rd_done in HOLD); frame_done high for the cycle after the following edge, by which time all closing-frame writes are complete.
- Read latency 1: rd_en sampled at edge t → rd_data/rd_valid at t+1 for one cycle; rd_data holds last value when rd_valid=0.
- rd_done and closing acq_end on the same edge: release takes effect first, swap happens, no ovf.
- Reset mid-frame: all state and both banks return to reset values immediately.

## Test plan
- NB=4,CW=4,NPIX=2,ACQ_NUM=3: 5 hits pix0 addr3 over 3 acq_end → his_num 0→1, frame_done one pulse, read [0][3] → rd_data=5, second read → 0.
- 20 consecutive-cycle hits pix1 addr7, CW=4 → bin reads 15 (saturated), neighbouring bins 0.
- Alternating same-bin hits every cycle across closing acq_end → closing-cycle hit in old bank, next-cycle hit in new bank; totals exact.
- Close frame 1, no rd_done, complete 3 more acq_end → ovf=1, state HOLD, hits dropped; rd_done → his_num toggles, frame_done pulses, dropped hits absent.
- rd_done on same edge as closing acq_end → swap, ovf stays 0.
- Assert res mid-frame with nonzero bins → all outputs reset values, every bin reads 0 after release.
